fifo_dac: RTL and testbench

- Output-direction sample FIFO; the transmit counterpart of the ADC capture FIFO.
- The control block (APB side) pushes samples with single-cycle write strobes.
- The DAC/stimulation front end pulls one sample per rising edge of its level-type request, and receives a registered sample plus a one-cycle valid pulse.
- Reports fill level, a programmable low-water flag, and sticky underrun / write-drop flags for interrupt generation.

---
 rtl/fifo_dac.sv | 127 ++++++++++++
 tb/tb_fifo_dac.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_dac.sv
// Transmit sample FIFO: control block pushes samples, DAC front end pulls one
// sample per rising edge of its level request and gets a registered sample
// plus a one-cycle valid pulse. Reports fill level, low-water and sticky flags.
module fifo_dac #(
  parameter int unsigned W_FIFO = 4,
  parameter int unsigned W_DATA = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                write_req_i,
  input  logic [W_DATA-1:0]   data_i,
  input  logic                clr_flags_i,
  input  logic [W_FIFO:0]     thresh_i,
  output logic [W_FIFO:0]     fill_level_o,
  output logic                full_o,
  output logic                low_o,
  output logic                undrflw_o,
  output logic                wr_drop_o,
  input  logic                sample_req_i,
  output logic [W_DATA-1:0]   sample_o,
  output logic                sample_valid_o
);

  localparam int unsigned N_ENTRIES = 2 ** W_FIFO;
  localparam int unsigned W_CNT     = W_FIFO + 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [W_DATA-1:0]   mem [N_ENTRIES];
  logic [W_FIFO-1:0]   r_pnt, w_pnt;
  logic [W_CNT-1:0]    count;
  logic                full_c;
  logic                pop_c;
  logic                under_c;
  logic                wr_accept_c;
  logic                drop_c;

  assign full_c       = (count == W_CNT'(N_ENTRIES));
  assign wr_accept_c  = write_req_i && (!full_c || pop_c);
  assign drop_c       = write_req_i && !wr_accept_c;

  assign fill_level_o = count;
  assign full_o       = full_c;
  assign low_o        = (count <= thresh_i);

  // Read FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next state: one pop (or underrun) per request high-phase
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    under_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_req_i) begin
          state_d = HOLD;
          if (count != '0) begin
            pop_c = 1'b1;
          end else begin
            under_c = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!sample_req_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_accept_c) begin
      mem[w_pnt] <= data_i;
    end
  end

  // Pointers, occupancy count and output sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pnt          <= '0;
      w_pnt          <= '0;
      count          <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
    end else begin
      sample_valid_o <= pop_c;
      if (pop_c) begin
        sample_o <= mem[r_pnt];
        r_pnt    <= r_pnt + W_FIFO'(1);
      end
      if (wr_accept_c) begin
        w_pnt <= w_pnt + W_FIFO'(1);
      end
      case ({wr_accept_c, pop_c})
        2'b10:   count <= count + W_CNT'(1);
        2'b01:   count <= count - W_CNT'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags; a set event in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      undrflw_o <= 1'b0;
      wr_drop_o <= 1'b0;
    end else begin
      undrflw_o <= under_c | (undrflw_o & ~clr_flags_i);
      wr_drop_o <= drop_c  | (wr_drop_o & ~clr_flags_i);
    end
  end

endmodule

// File: tb/tb_fifo_dac.sv
// Bench for fifo_dac: directed scenarios then random traffic, checked against
// a queue-based reference model with a scoreboard of expected samples.
module tb_fifo_dac;

  localparam int unsigned W_FIFO = 4;
  localparam int unsigned W_DATA = 32;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              write_req_i;
  logic [W_DATA-1:0] data_i;
  logic              clr_flags_i;
  logic [W_FIFO:0]   thresh_i;
  logic [W_FIFO:0]   fill_level_o;
  logic              full_o;
  logic              low_o;
  logic              undrflw_o;
  logic              wr_drop_o;
  logic              sample_req_i;
  logic [W_DATA-1:0] sample_o;
  logic              sample_valid_o;

  fifo_dac #(.W_FIFO(W_FIFO), .W_DATA(W_DATA)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .write_req_i    (write_req_i),
    .data_i         (data_i),
    .clr_flags_i    (clr_flags_i),
    .thresh_i       (thresh_i),
    .fill_level_o   (fill_level_o),
    .full_o         (full_o),
    .low_o          (low_o),
    .undrflw_o      (undrflw_o),
    .wr_drop_o      (wr_drop_o),
    .sample_req_i   (sample_req_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [W_DATA-1:0] act,
                     input logic [W_DATA-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, one pop per request high-phase
  logic [W_DATA-1:0] mq[$];
  logic [W_DATA-1:0] exp_samples[$];
  logic              armed;
  logic              m_und;
  logic              m_drop;
  logic              m_valid;
  logic [W_DATA-1:0] m_sample;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_samples.delete();
      armed    <= 1'b1;
      m_und    <= 1'b0;
      m_drop   <= 1'b0;
      m_valid  <= 1'b0;
      m_sample <= '0;
    end else begin
      bit do_pop;
      bit do_under;
      bit wr_ok;
      logic [W_DATA-1:0] v;
      do_pop   = sample_req_i && armed && (mq.size() > 0);
      do_under = sample_req_i && armed && (mq.size() == 0);
      wr_ok    = write_req_i && ((mq.size() < DEPTH) || do_pop);
      armed   <= !sample_req_i;
      m_valid <= do_pop;
      if (do_pop) begin
        v = mq.pop_front();
        exp_samples.push_back(v);
        m_sample <= v;
      end
      if (wr_ok) mq.push_back(data_i);
      m_und  <= do_under | (m_und & ~clr_flags_i);
      m_drop <= (write_req_i && !wr_ok) | (m_drop & ~clr_flags_i);
    end
  end

  // Monitor: compare status every cycle, pop the scoreboard on each valid pulse
  always @(negedge clk) begin
    chk("fill_level", W_DATA'(fill_level_o), W_DATA'(mq.size()));
    chk("full", W_DATA'(full_o), W_DATA'(mq.size() == DEPTH));
    chk("low", W_DATA'(low_o), W_DATA'(mq.size() <= int'(thresh_i)));
    chk("undrflw", W_DATA'(undrflw_o), W_DATA'(m_und));
    chk("wr_drop", W_DATA'(wr_drop_o), W_DATA'(m_drop));
    chk("sample_valid", W_DATA'(sample_valid_o), W_DATA'(m_valid));
    chk("sample_o_held", sample_o, m_sample);
    if (sample_valid_o) begin
      if (exp_samples.size() == 0) begin
        chk("unexpected_pulse", W_DATA'(1), W_DATA'(0));
      end else begin
        chk("scoreboard", sample_o, exp_samples.pop_front());
      end
    end else if (m_valid && exp_samples.size() > 0) begin
      void'(exp_samples.pop_front());
    end
  end

  task automatic cyc(input bit wr, input logic [W_DATA-1:0] d, input bit req,
                     input bit clr);
    write_req_i  = wr;
    data_i       = d;
    sample_req_i = req;
    clr_flags_i  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n, input int low_cycles);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      for (int j = 0; j < low_cycles; j++) cyc(1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bit req_r;
    rst_n        = 1'b0;
    write_req_i  = 1'b0;
    data_i       = '0;
    clr_flags_i  = 1'b0;
    sample_req_i = 1'b0;
    thresh_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);

    // Four writes then four 1-high/3-low request pulses
    for (int i = 1; i <= 4; i++) cyc(1'b1, W_DATA'(i * 32'h11), 1'b0, 1'b0);
    pulses(4, 3);

    // Overfill by one, then drain to exercise pointer wrap
    for (int i = 0; i < 17; i++) cyc(1'b1, W_DATA'(32'h100 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    pulses(16, 1);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Long request with three entries: single pop
    for (int i = 0; i < 3; i++) cyc(1'b1, W_DATA'(32'h200 + i), 1'b0, 1'b0);
    repeat (10) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    pulses(2, 1);

    // Underrun; clear coinciding with a second underrun keeps the flag
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Full FIFO: write and pop in the same cycle, low-water at 15
    thresh_i = 5'd15;
    for (int i = 0; i < 16; i++) cyc(1'b1, W_DATA'(32'h300 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0abc, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    pulses(16, 1);

    // Random traffic with a mid-run reset while the request is held high
    req_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) thresh_i = (W_FIFO + 1)'($urandom_range(0, 20));
      if ($urandom_range(0, 2) == 0) req_r = ~req_r;
      if (i == 1500) begin
        rst_n = 1'b0;
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b0);
        req_r = 1'b1;
      end
      cyc(1'($urandom_range(0, 1)), $urandom, req_r,
          ($urandom_range(0, 15) == 0));
    end
    repeat (4) cyc(1'b0, '0, 1'b0, 1'b0);

    chk("scoreboard_drained", W_DATA'(exp_samples.size()), W_DATA'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
